execution_sequencer: RTL and testbench
======================================

// Module: execution_sequencer
// PURPOSE
// - Top-level controller for the execution engine. Accepts one command at a time, then fetches its parameters.
// - Runs an optional authorization check, then dispatches the command to exactly one of seven engine FSMs.
// - Reports success or failure to the control unit and holds the report until control_ack.
// - Sits between the command/control unit and the per-resource FSMs: NVM, VM, RNG, ASYM, SYM, HASH, KEYGEN.
// PARAMETERS
// - NUM_ENG         7     number of dispatch targets; index = cmd_class
// - TIMEOUT_CYCLES  1024  maximum cycles in FETCH, AUTH or WAIT before a timeout error; must be >= 2
// - CLASS_W         3     width of cmd_class
// PORTS
// - clk              in   1        single clock; all logic on posedge
// - rst              in   1        asynchronous, active-high reset
// - cmd_valid        in   1        a command is offered
// - cmd_class        in   CLASS_W  target engine index
// - cmd_needs_auth   in   1        command requires an authorization check
// - cmd_ready        out  1        sequencer can accept a command
// - fetch_params     out  1        1-cycle pulse: request the command parameters
// - params_loaded    in   1        parameters are available
// - auth_start       out  1        1-cycle pulse to authorization_fsm
// - auth_success     in   1        authorization passed (pulse)
// - auth_fail        in   1        authorization failed (pulse)
// - eng_start        out  NUM_ENG  one-hot, 1-cycle start pulse to the selected engine
// - eng_done         in   NUM_ENG  per-engine completion (pulse)
// - eng_fail         in   NUM_ENG  per-engine failure (pulse)
// - exec_done        out  1        level; held until control_ack
// - exec_error       out  1        level; held until control_ack
// - err_code         out  3        0 none, 1 auth, 2 engine, 3 timeout, 4 bad class; valid while exec_error=1
// - control_ack      in   1        control unit has consumed the done or error report
// - busy             out  1        high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, class_q=0, auth_q=0, tmo_cnt=0. Outputs on reset: cmd_ready=1; all other outputs 0.
// - All outputs are registered; there is no combinational path from inputs to outputs.
// - IDLE: cmd_ready=1. On cmd_valid: latch class_q and auth_q, drive cmd_ready=0, pulse fetch_params next cycle, go to FETCH.
// - FETCH: on params_loaded, check class_q.
//   - class_q >= NUM_ENG: go to ERROR with code 4.
//   - auth_q=1: pulse auth_start, go to AUTH.
//   - auth_q=0: pulse eng_start[class_q], go to WAIT.
// - AUTH: on auth_success, pulse eng_start[class_q] and go to WAIT. On auth_fail, go to ERROR with code 1.
//   - If auth_success and auth_fail arrive in the same cycle, auth_fail wins.
// - WAIT: only eng_done[class_q] and eng_fail[class_q] are observed; done/fail from other engines is ignored.
//   - fail: go to ERROR with code 2. Done alone: go to DONE. Done and fail together: fail wins (code 2).
// - DONE: exec_done=1 until control_ack, then go to IDLE.
// - ERROR: exec_error=1 and err_code stable until control_ack, then go to IDLE; err_code clears to 0.
// - Ack timing: control_ack in the same cycle as entry into DONE or ERROR is honoured, so the report lasts at least 1 cycle.
// - Timeout: tmo_cnt clears on every state change and increments each cycle in FETCH, AUTH and WAIT.
//   - When tmo_cnt reaches TIMEOUT_CYCLES-1 with no exit event: go to ERROR with code 3.
//   - An exit event in that same cycle takes priority over the timeout.
// - Minimum latency with no auth, cmd_valid to exec_done: 1 cycle to FETCH + params_loaded + 1 + eng_done + 1.
// - Reset mid-operation: immediate return to IDLE. No report is issued and no ack is required.
// - Outside the dispatch step, eng_start is always all zeros, and at most one bit is set at any time.
// STRUCTURE
// - Shared package exec_pkg: state enum, err_code constants, engine index constants (ENG_NVM=0 .. ENG_KEYGEN=6).
// - One sub-module: exec_timeout_ctr, a loadable counter with clear/enable inputs and an expired output.
// TESTING
// - No auth, class 5 (HASH): params_loaded at cycle 3, eng_done[5] at cycle 8 -> eng_start=7'b0100000 for exactly 1 cycle;
//   exec_done=1 from cycle 9 until control_ack; err_code=0.
// - Auth, class 0 (NVM): auth_fail -> exec_error=1, err_code=1, eng_start never asserted.
// - Class 2 (RNG): eng_done[3] and eng_fail[4] pulsed -> both ignored; then eng_done[2] and eng_fail[2] in the same cycle -> err_code=2.
// - Class 7 -> err_code=4 right after params_loaded. With TIMEOUT_CYCLES=16 and no eng_done -> err_code=3 exactly 16 cycles after WAIT entry.
// - rst asserted in WAIT -> all outputs 0 and cmd_ready=1 asynchronously; a new command is then accepted normally.
// - Back-to-back: control_ack in the cycle DONE is entered -> cmd_ready=1 next cycle; a second cmd_valid is accepted that cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execution sequencer: FSM states,
// report codes and engine indices (index = cmd_class).
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_AUTH,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_AUTH    = 3'd1;
    localparam logic [2:0] ERR_ENGINE  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CLASS   = 3'd4;

    localparam int ENG_NVM    = 0;
    localparam int ENG_VM     = 1;
    localparam int ENG_RNG    = 2;
    localparam int ENG_ASYM   = 3;
    localparam int ENG_SYM    = 4;
    localparam int ENG_HASH   = 5;
    localparam int ENG_KEYGEN = 6;

endpackage

// File: rtl/execution_sequencer_if.sv
// Command, dispatch and report signals between the control unit, the
// sequencer and the per-resource engine FSMs.
interface execution_sequencer_if #(
    parameter int NUM_ENG = 7,
    parameter int CLASS_W = 3
);
    logic               cmd_valid;
    logic [CLASS_W-1:0] cmd_class;
    logic               cmd_needs_auth;
    logic               cmd_ready;
    logic               fetch_params;
    logic               params_loaded;
    logic               auth_start;
    logic               auth_success;
    logic               auth_fail;
    logic [NUM_ENG-1:0] eng_start;
    logic [NUM_ENG-1:0] eng_done;
    logic [NUM_ENG-1:0] eng_fail;
    logic               exec_done;
    logic               exec_error;
    logic [2:0]         err_code;
    logic               control_ack;
    logic               busy;

    modport master (
        output cmd_valid, cmd_class, cmd_needs_auth, params_loaded,
               auth_success, auth_fail, eng_done, eng_fail, control_ack,
        input  cmd_ready, fetch_params, auth_start, eng_start,
               exec_done, exec_error, err_code, busy
    );

    modport slave (
        input  cmd_valid, cmd_class, cmd_needs_auth, params_loaded,
               auth_success, auth_fail, eng_done, eng_fail, control_ack,
        output cmd_ready, fetch_params, auth_start, eng_start,
               exec_done, exec_error, err_code, busy
    );

endinterface

// File: rtl/exec_timeout_ctr.sv
// Stall watchdog counter: counts while enabled, clear wins over load,
// expired flags the last allowed cycle.
module exec_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (clr) begin
            tmo_cnt <= '0;
        end else if (load) begin
            tmo_cnt <= load_val;
        end else if (en) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign expired = (tmo_cnt == LAST);

endmodule

// File: rtl/execution_sequencer.sv
// Accepts one command, fetches parameters, optionally authorizes, dispatches
// to one engine and holds a done/error report until control_ack.
//
// state    | meaning
// IDLE     | cmd_ready high, waiting for cmd_valid
// FETCH    | fetch_params issued, waiting for params_loaded
// AUTH     | auth_start issued, waiting for auth_success / auth_fail
// WAIT     | engine started, waiting for its done / fail
// DONE     | exec_done held until control_ack
// ERROR    | exec_error + err_code held until control_ack
module execution_sequencer
    import exec_pkg::*;
#(
    parameter int NUM_ENG        = 7,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CLASS_W        = 3
) (
    input logic                  clk,
    input logic                  rst,
    execution_sequencer_if.slave bus
);

    localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [NUM_ENG-1:0] ENG_ONE   = NUM_ENG'(1);
    localparam logic [CLASS_W:0]   NUM_ENG_W = (CLASS_W + 1)'(NUM_ENG);

    state_t             state;
    logic [CLASS_W-1:0] class_q;
    logic               auth_q;
    logic [NUM_ENG-1:0] sel_mask;
    logic               done_sel;
    logic               fail_sel;
    logic               tmo_expired;
    logic               tmo_en;
    logic               tmo_clr;

    // Only the dispatched engine's done/fail is visible to the FSM.
    always_comb begin
        sel_mask = ENG_ONE << class_q;
        done_sel = |(bus.eng_done & sel_mask);
        fail_sel = |(bus.eng_fail & sel_mask);
        tmo_en   = (state == ST_FETCH) || (state == ST_AUTH) || (state == ST_WAIT);
        tmo_clr  = 1'b0;
        case (state)
            ST_IDLE:  tmo_clr = bus.cmd_valid;
            ST_FETCH: tmo_clr = bus.params_loaded || tmo_expired;
            ST_AUTH:  tmo_clr = bus.auth_success || bus.auth_fail || tmo_expired;
            ST_WAIT:  tmo_clr = done_sel || fail_sel || tmo_expired;
            ST_DONE,
            ST_ERROR: tmo_clr = bus.control_ack;
            default:  tmo_clr = 1'b1;
        endcase
    end

    exec_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .load    (1'b0),
        .load_val('0),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            class_q          <= '0;
            auth_q           <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.fetch_params <= 1'b0;
            bus.auth_start   <= 1'b0;
            bus.eng_start    <= '0;
            bus.exec_done    <= 1'b0;
            bus.exec_error   <= 1'b0;
            bus.err_code     <= ERR_NONE;
            bus.busy         <= 1'b0;
        end else begin
            bus.fetch_params <= 1'b0;
            bus.auth_start   <= 1'b0;
            bus.eng_start    <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        class_q          <= bus.cmd_class;
                        auth_q           <= bus.cmd_needs_auth;
                        bus.cmd_ready    <= 1'b0;
                        bus.fetch_params <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus.params_loaded) begin
                        if ({1'b0, class_q} >= NUM_ENG_W) begin
                            bus.exec_error <= 1'b1;
                            bus.err_code   <= ERR_CLASS;
                            state          <= ST_ERROR;
                        end else if (auth_q) begin
                            bus.auth_start <= 1'b1;
                            state          <= ST_AUTH;
                        end else begin
                            bus.eng_start <= sel_mask;
                            state         <= ST_WAIT;
                        end
                    end else if (tmo_expired) begin
                        bus.exec_error <= 1'b1;
                        bus.err_code   <= ERR_TIMEOUT;
                        state          <= ST_ERROR;
                    end
                end
                ST_AUTH: begin
                    if (bus.auth_fail) begin
                        bus.exec_error <= 1'b1;
                        bus.err_code   <= ERR_AUTH;
                        state          <= ST_ERROR;
                    end else if (bus.auth_success) begin
                        bus.eng_start <= sel_mask;
                        state         <= ST_WAIT;
                    end else if (tmo_expired) begin
                        bus.exec_error <= 1'b1;
                        bus.err_code   <= ERR_TIMEOUT;
                        state          <= ST_ERROR;
                    end
                end
                ST_WAIT: begin
                    if (fail_sel) begin
                        bus.exec_error <= 1'b1;
                        bus.err_code   <= ERR_ENGINE;
                        state          <= ST_ERROR;
                    end else if (done_sel) begin
                        bus.exec_done <= 1'b1;
                        state         <= ST_DONE;
                    end else if (tmo_expired) begin
                        bus.exec_error <= 1'b1;
                        bus.err_code   <= ERR_TIMEOUT;
                        state          <= ST_ERROR;
                    end
                end
                ST_DONE: begin
                    if (bus.control_ack) begin
                        bus.exec_done <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (bus.control_ack) begin
                        bus.exec_error <= 1'b0;
                        bus.err_code   <= ERR_NONE;
                        bus.cmd_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execution_sequencer.sv
// Directed bench for execution_sequencer; outputs sampled on the falling edge,
// inputs driven there for the next rising edge. TIMEOUT_CYCLES = 16.
module tb_execution_sequencer;
    import exec_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    execution_sequencer_if #(.NUM_ENG(7), .CLASS_W(3)) bus ();

    execution_sequencer #(
        .NUM_ENG       (7),
        .TIMEOUT_CYCLES(16),
        .CLASS_W       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cmd_valid      = 1'b0;
        bus.cmd_class      = 3'd0;
        bus.cmd_needs_auth = 1'b0;
        bus.params_loaded  = 1'b0;
        bus.auth_success   = 1'b0;
        bus.auth_fail      = 1'b0;
        bus.eng_done       = 7'd0;
        bus.eng_fail       = 7'd0;
        bus.control_ack    = 1'b0;
    endtask

    // Offers a command for one cycle; returns in the first FETCH cycle.
    task automatic issue_cmd(input logic [2:0] cls, input logic auth);
        bus.cmd_valid      = 1'b1;
        bus.cmd_class      = cls;
        bus.cmd_needs_auth = auth;
        tick();
        bus.cmd_valid      = 1'b0;
    endtask

    task automatic ack_report();
        bus.control_ack = 1'b1;
        tick();
        bus.control_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.eng_start !== 7'd0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", bus.eng_start); end
        checks++; if ({bus.exec_done, bus.exec_error, bus.err_code} !== 5'd0) begin errors++; $display("FAIL reset_report: got %b want 00000", {bus.exec_done, bus.exec_error, bus.err_code}); end
        checks++; if ({bus.fetch_params, bus.auth_start} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {bus.fetch_params, bus.auth_start}); end
        rst = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_hash_no_auth();
        int starts;
        starts = 0;
        bus.cmd_valid      = 1'b1;
        bus.cmd_class      = 3'(ENG_HASH);
        bus.cmd_needs_auth = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hash_ready_c0: got %b want 1", bus.cmd_ready); end
        tick(); // c1
        bus.cmd_valid = 1'b0;
        if (bus.eng_start !== 7'd0) starts++;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL hash_ready_c1: got %b want 0", bus.cmd_ready); end
        checks++; if (bus.fetch_params !== 1'b1) begin errors++; $display("FAIL hash_fetch_c1: got %b want 1", bus.fetch_params); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hash_busy_c1: got %b want 1", bus.busy); end
        tick(); // c2
        if (bus.eng_start !== 7'd0) starts++;
        checks++; if (bus.fetch_params !== 1'b0) begin errors++; $display("FAIL hash_fetch_c2: got %b want 0", bus.fetch_params); end
        tick(); // c3
        bus.params_loaded = 1'b1;
        checks++; if (bus.eng_start !== 7'd0) begin errors++; $display("FAIL hash_start_c3: got %b want 0", bus.eng_start); end
        tick(); // c4
        bus.params_loaded = 1'b0;
        if (bus.eng_start !== 7'd0) starts++;
        checks++; if (bus.eng_start !== 7'b0100000) begin errors++; $display("FAIL hash_start_c4: got %b want 0100000", bus.eng_start); end
        for (int i = 0; i < 3; i++) begin // c5..c7
            tick();
            if (bus.eng_start !== 7'd0) starts++;
        end
        tick(); // c8
        bus.eng_done = 7'b0100000;
        checks++; if (bus.exec_done !== 1'b0) begin errors++; $display("FAIL hash_done_c8: got %b want 0", bus.exec_done); end
        tick(); // c9
        bus.eng_done = 7'd0;
        checks++; if (bus.exec_done !== 1'b1) begin errors++; $display("FAIL hash_done_c9: got %b want 1", bus.exec_done); end
        checks++; if ({bus.exec_error, bus.err_code} !== 4'd0) begin errors++; $display("FAIL hash_err_c9: got %b want 0000", {bus.exec_error, bus.err_code}); end
        tick(); // c10
        checks++; if (bus.exec_done !== 1'b1) begin errors++; $display("FAIL hash_done_hold: got %b want 1", bus.exec_done); end
        ack_report(); // c11
        checks++; if (bus.exec_done !== 1'b0) begin errors++; $display("FAIL hash_done_clear: got %b want 0", bus.exec_done); end
        checks++; if ({bus.cmd_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL hash_idle: got %b want 10", {bus.cmd_ready, bus.busy}); end
        checks++; if (starts !== 1) begin errors++; $display("FAIL hash_start_count: got %0d want 1", starts); end
    endtask

    task automatic test_auth_fail();
        issue_cmd(3'(ENG_NVM), 1'b1); // c1
        bus.params_loaded = 1'b1;
        tick(); // c2
        bus.params_loaded = 1'b0;
        checks++; if (bus.auth_start !== 1'b1) begin errors++; $display("FAIL authf_start: got %b want 1", bus.auth_start); end
        checks++; if (bus.eng_start !== 7'd0) begin errors++; $display("FAIL authf_eng_c2: got %b want 0", bus.eng_start); end
        bus.auth_fail = 1'b1;
        tick(); // c3
        bus.auth_fail = 1'b0;
        checks++; if ({bus.exec_error, bus.err_code} !== 4'b1001) begin errors++; $display("FAIL authf_report: got %b want 1001", {bus.exec_error, bus.err_code}); end
        checks++; if ({bus.eng_start, bus.auth_start, bus.exec_done} !== 9'd0) begin errors++; $display("FAIL authf_quiet: got %b want 0", {bus.eng_start, bus.auth_start, bus.exec_done}); end
        ack_report(); // c4
        checks++; if ({bus.exec_error, bus.err_code, bus.cmd_ready} !== 5'b00001) begin errors++; $display("FAIL authf_clear: got %b want 00001", {bus.exec_error, bus.err_code, bus.cmd_ready}); end
    endtask

    task automatic test_auth_paths();
        issue_cmd(3'(ENG_VM), 1'b1);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        bus.auth_success  = 1'b1;
        bus.auth_fail     = 1'b1;
        tick();
        bus.auth_success  = 1'b0;
        bus.auth_fail     = 1'b0;
        checks++; if ({bus.exec_error, bus.err_code} !== 4'b1001) begin errors++; $display("FAIL auth_both_report: got %b want 1001", {bus.exec_error, bus.err_code}); end
        checks++; if (bus.eng_start !== 7'd0) begin errors++; $display("FAIL auth_both_eng: got %b want 0", bus.eng_start); end
        ack_report();

        issue_cmd(3'(ENG_ASYM), 1'b1);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        bus.auth_success  = 1'b1;
        tick();
        bus.auth_success  = 1'b0;
        checks++; if (bus.eng_start !== 7'b0001000) begin errors++; $display("FAIL auth_ok_eng: got %b want 0001000", bus.eng_start); end
        bus.eng_done = 7'b0001000;
        tick();
        bus.eng_done = 7'd0;
        checks++; if ({bus.exec_done, bus.exec_error} !== 2'b10) begin errors++; $display("FAIL auth_ok_done: got %b want 10", {bus.exec_done, bus.exec_error}); end
        ack_report();
    endtask

    task automatic test_ignore_other();
        issue_cmd(3'(ENG_RNG), 1'b0);
        bus.params_loaded = 1'b1;
        tick(); // WAIT
        bus.params_loaded = 1'b0;
        checks++; if (bus.eng_start !== 7'b0000100) begin errors++; $display("FAIL rng_eng_start: got %b want 0000100", bus.eng_start); end
        bus.eng_done = 7'b0001000;
        bus.eng_fail = 7'b0010000;
        tick();
        checks++; if ({bus.exec_done, bus.exec_error, bus.busy} !== 3'b001) begin errors++; $display("FAIL rng_ignore: got %b want 001", {bus.exec_done, bus.exec_error, bus.busy}); end
        bus.eng_done = 7'b0000100;
        bus.eng_fail = 7'b0000100;
        tick();
        bus.eng_done = 7'd0;
        bus.eng_fail = 7'd0;
        checks++; if ({bus.exec_done, bus.exec_error, bus.err_code} !== 5'b01010) begin errors++; $display("FAIL rng_fail_wins: got %b want 01010", {bus.exec_done, bus.exec_error, bus.err_code}); end
        ack_report();
    endtask

    task automatic test_bad_class();
        issue_cmd(3'd7, 1'b1);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        checks++; if ({bus.exec_error, bus.err_code} !== 4'b1100) begin errors++; $display("FAIL bad_class_report: got %b want 1100", {bus.exec_error, bus.err_code}); end
        checks++; if ({bus.auth_start, bus.eng_start} !== 8'd0) begin errors++; $display("FAIL bad_class_quiet: got %b want 0", {bus.auth_start, bus.eng_start}); end
        ack_report();
        checks++; if ({bus.exec_error, bus.err_code} !== 4'd0) begin errors++; $display("FAIL bad_class_clear: got %b want 0000", {bus.exec_error, bus.err_code}); end
    endtask

    task automatic test_timeout();
        issue_cmd(3'(ENG_KEYGEN), 1'b0);
        bus.params_loaded = 1'b1;
        tick(); // first WAIT cycle
        bus.params_loaded = 1'b0;
        repeat (15) tick();
        checks++; if (bus.exec_error !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", bus.exec_error); end
        tick(); // 16 cycles after WAIT entry
        checks++; if ({bus.exec_done, bus.exec_error, bus.err_code} !== 5'b01011) begin errors++; $display("FAIL tmo_report: got %b want 01011", {bus.exec_done, bus.exec_error, bus.err_code}); end
        ack_report();
        checks++; if ({bus.exec_error, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL tmo_clear: got %b want 01", {bus.exec_error, bus.cmd_ready}); end

        issue_cmd(3'(ENG_SYM), 1'b0);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        repeat (15) tick();
        bus.eng_done = 7'b0010000;
        tick();
        bus.eng_done = 7'd0;
        checks++; if ({bus.exec_done, bus.exec_error} !== 2'b10) begin errors++; $display("FAIL tmo_done_priority: got %b want 10", {bus.exec_done, bus.exec_error}); end
        ack_report();
    endtask

    task automatic test_reset_mid();
        issue_cmd(3'(ENG_NVM), 1'b0);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        tick(); // in WAIT
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.cmd_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL rst_mid_ready_busy: got %b want 10", {bus.cmd_ready, bus.busy}); end
        checks++; if ({bus.eng_start, bus.exec_done, bus.exec_error, bus.err_code, bus.fetch_params, bus.auth_start} !== 14'd0) begin errors++; $display("FAIL rst_mid_outputs: got %b want 0", {bus.eng_start, bus.exec_done, bus.exec_error, bus.err_code, bus.fetch_params, bus.auth_start}); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({bus.exec_done, bus.exec_error, bus.cmd_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_no_report: got %b want 001", {bus.exec_done, bus.exec_error, bus.cmd_ready}); end
        issue_cmd(3'(ENG_SYM), 1'b0);
        checks++; if (bus.fetch_params !== 1'b1) begin errors++; $display("FAIL rst_mid_new_fetch: got %b want 1", bus.fetch_params); end
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        checks++; if (bus.eng_start !== 7'b0010000) begin errors++; $display("FAIL rst_mid_new_start: got %b want 0010000", bus.eng_start); end
        bus.eng_done = 7'b0010000;
        tick();
        bus.eng_done = 7'd0;
        checks++; if (bus.exec_done !== 1'b1) begin errors++; $display("FAIL rst_mid_new_done: got %b want 1", bus.exec_done); end
        ack_report();
    endtask

    task automatic test_back_to_back();
        issue_cmd(3'(ENG_HASH), 1'b0);
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        bus.eng_done = 7'b0100000;
        tick(); // first DONE cycle
        bus.eng_done = 7'd0;
        checks++; if (bus.exec_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.exec_done); end
        bus.control_ack = 1'b1;
        tick();
        bus.control_ack = 1'b0;
        checks++; if ({bus.cmd_ready, bus.exec_done, bus.busy} !== 3'b100) begin errors++; $display("FAIL b2b_idle: got %b want 100", {bus.cmd_ready, bus.exec_done, bus.busy}); end
        issue_cmd(3'(ENG_RNG), 1'b0);
        checks++; if ({bus.cmd_ready, bus.fetch_params, bus.busy} !== 3'b011) begin errors++; $display("FAIL b2b_accept: got %b want 011", {bus.cmd_ready, bus.fetch_params, bus.busy}); end
        bus.params_loaded = 1'b1;
        tick();
        bus.params_loaded = 1'b0;
        checks++; if (bus.eng_start !== 7'b0000100) begin errors++; $display("FAIL b2b_start: got %b want 0000100", bus.eng_start); end
        bus.eng_done = 7'b0000100;
        tick();
        bus.eng_done = 7'd0;
        checks++; if (bus.exec_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", bus.exec_done); end
        ack_report();
    endtask

    task automatic test_dispatch_all();
        int         engs[7];
        logic [6:0] exp_start;
        engs = '{ENG_NVM, ENG_VM, ENG_RNG, ENG_ASYM, ENG_SYM, ENG_HASH, ENG_KEYGEN};
        for (int i = 0; i < 7; i++) begin
            issue_cmd(3'(engs[i]), 1'b0);
            bus.params_loaded = 1'b1;
            tick();
            bus.params_loaded = 1'b0;
            exp_start = 7'b0000001 << engs[i];
            checks++; if (bus.eng_start !== exp_start) begin errors++; $display("FAIL dispatch_%0d_start: got %b want %b", engs[i], bus.eng_start, exp_start); end
            bus.eng_done = exp_start;
            tick();
            bus.eng_done = 7'd0;
            checks++; if ({bus.exec_done, bus.eng_start} !== 8'b10000000) begin errors++; $display("FAIL dispatch_%0d_done: got %b want 10000000", engs[i], {bus.exec_done, bus.eng_start}); end
            ack_report();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hash_no_auth();
        test_auth_fail();
        test_auth_paths();
        test_ignore_other();
        test_bad_class();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_dispatch_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
